// File: rtl/nn_pkg.sv
// nn_pkg: shared constants and FSM state encoding for the output-layer
// decision stage (digit_argmax and argmax_cmp).
package nn_pkg;

  localparam int DATA_W    = 8;
  localparam int N_CLASSES = 10;
  localparam int IDX_W     = 4;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

endpackage

// File: rtl/argmax_cmp.sv
// argmax_cmp: combinational compare/select of the running (max, index) pair
// against the incoming beat. With DIGIT_ARGMAX_MARGIN_EN defined it also
// updates the runner-up value; otherwise the runner-up ports do not exist.
module argmax_cmp
  import nn_pkg::*;
#(
  parameter int DATA_W = nn_pkg::DATA_W,
  parameter int IDX_W  = nn_pkg::IDX_W
) (
  input  logic              first,
  input  logic [DATA_W-1:0] cur_max,
  input  logic [IDX_W-1:0]  cur_idx,
  input  logic [DATA_W-1:0] beat_data,
  input  logic [IDX_W-1:0]  beat_idx,
`ifdef DIGIT_ARGMAX_MARGIN_EN
  input  logic [DATA_W-1:0] cur_ru,
  output logic [DATA_W-1:0] nxt_ru,
`endif
  output logic [DATA_W-1:0] nxt_max,
  output logic [IDX_W-1:0]  nxt_idx
);

  logic new_max;

  // Strictly greater keeps the lower index on ties.
  assign new_max = (beat_data > cur_max);

  // Max/index select: first beat seeds unconditionally, later beats only on a strict win.
  always_comb begin
    nxt_max = cur_max;
    nxt_idx = cur_idx;
    if (first) begin
      nxt_max = beat_data;
      nxt_idx = '0;
    end else if (new_max) begin
      nxt_max = beat_data;
      nxt_idx = beat_idx;
    end
  end

`ifdef DIGIT_ARGMAX_MARGIN_EN
  // Runner-up select: a displaced max drops to runner-up, else a beat above the runner-up replaces it.
  always_comb begin
    nxt_ru = cur_ru;
    if (first) begin
      nxt_ru = '0;
    end else if (new_max) begin
      nxt_ru = cur_max;
    end else if (beat_data > cur_ru) begin
      nxt_ru = beat_data;
    end
  end
`endif

endmodule

// File: rtl/digit_argmax.sv
// digit_argmax: tracks the running maximum activation over one frame of
// class activations and emits digit/score/error over a valid/ready handshake.
// Optional feature macro: DIGIT_ARGMAX_MARGIN_EN (runner-up tracking and
// out_margin = score - runner-up); when undefined out_margin is tied to 0.
module digit_argmax
  import nn_pkg::*;
#(
  parameter int N_CLASSES = nn_pkg::N_CLASSES,
  parameter int DATA_W    = nn_pkg::DATA_W,
  parameter int IDX_W     = nn_pkg::IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_digit,
  output logic [DATA_W-1:0] out_score,
  output logic              out_err,
  output logic [DATA_W-1:0] out_margin
);

  localparam logic [IDX_W-1:0] FULL_CNT = IDX_W'(N_CLASSES);

  // Beat counter saturates at a full frame so oversize frames stay detectable.
  function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] c);
    return (c == FULL_CNT) ? c : c + 1'b1;
  endfunction

  state_t state_q, state_d;

  logic              accept, first, sat, end_frame;
  logic [IDX_W-1:0]  cnt_p0, cnt_inc;
  logic              ovf_p0, ovf_inc;
  logic [DATA_W-1:0] max_p0, cmp_max, trk_max;
  logic [IDX_W-1:0]  idx_p0, cmp_idx, trk_idx;
  logic [DATA_W-1:0] score_p1;
  logic [IDX_W-1:0]  digit_p1;
  logic              err_p1;

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign end_frame = accept && in_last;
  assign first     = (cnt_p0 == '0);
  assign sat       = (cnt_p0 == FULL_CNT);
  assign cnt_inc   = sat_inc(cnt_p0);
  assign ovf_inc   = ovf_p0 | sat;

`ifdef DIGIT_ARGMAX_MARGIN_EN
  logic [DATA_W-1:0] ru_p0, cmp_ru, trk_ru, margin_p1;
`endif

  argmax_cmp #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_cmp (
    .first     (first),
    .cur_max   (max_p0),
    .cur_idx   (idx_p0),
    .beat_data (in_data),
    .beat_idx  (cnt_p0),
`ifdef DIGIT_ARGMAX_MARGIN_EN
    .cur_ru    (ru_p0),
    .nxt_ru    (cmp_ru),
`endif
    .nxt_max   (cmp_max),
    .nxt_idx   (cmp_idx)
  );

  // Beats past a full frame are ignored by the tracker.
  assign trk_max = sat ? max_p0 : cmp_max;
  assign trk_idx = sat ? idx_p0 : cmp_idx;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ACCUM;
    else     state_q <= state_d;
  end

  // FSM next state: leave ACCUM on the last beat, leave DONE on the output handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (end_frame) state_d = DONE;
      DONE:    if (out_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // ---- stage p0: per-frame tracking (count, overflow, max, index) ----
  // Tracking registers advance per accepted beat and clear at end of frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p0 <= '0;
      ovf_p0 <= 1'b0;
      max_p0 <= '0;
      idx_p0 <= '0;
    end else if (accept) begin
      if (in_last) begin
        cnt_p0 <= '0;
        ovf_p0 <= 1'b0;
        max_p0 <= '0;
        idx_p0 <= '0;
      end else begin
        cnt_p0 <= cnt_inc;
        ovf_p0 <= ovf_inc;
        max_p0 <= trk_max;
        idx_p0 <= trk_idx;
      end
    end
  end

  // ---- stage p1: frame result held for the consumer ----
  // Result registers load on the last beat and hold through DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_p1 <= '0;
      digit_p1 <= '0;
      err_p1   <= 1'b0;
    end else if (end_frame) begin
      score_p1 <= trk_max;
      digit_p1 <= trk_idx;
      err_p1   <= (cnt_inc != FULL_CNT) || ovf_inc;
    end
  end

  assign out_score = score_p1;
  assign out_digit = digit_p1;
  assign out_err   = err_p1;

`ifdef DIGIT_ARGMAX_MARGIN_EN
  assign trk_ru = sat ? ru_p0 : cmp_ru;

  // Runner-up tracking and registered margin, aligned with the other results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ru_p0     <= '0;
      margin_p1 <= '0;
    end else if (accept) begin
      if (in_last) begin
        ru_p0     <= '0;
        margin_p1 <= trk_max - trk_ru;
      end else begin
        ru_p0     <= trk_ru;
      end
    end
  end

  assign out_margin = margin_p1;
`else
  assign out_margin = '0;
`endif

endmodule

// File: tb/tb_digit_argmax.sv
// tb_digit_argmax: directed self-checking bench for digit_argmax, plus a
// randomised frame sweep checked against a behavioural argmax model.
module tb_digit_argmax;

  localparam int N = 10;
`ifdef DIGIT_ARGMAX_MARGIN_EN
  localparam bit MEN = 1'b1;
`else
  localparam bit MEN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_last;
  logic [7:0] in_data;
  logic       out_valid, out_ready, out_err;
  logic [3:0] out_digit;
  logic [7:0] out_score, out_margin;

  int checks   = 0;
  int failures = 0;

  logic [7:0] fr [0:15];
  int         fr_len;

  always #5 clk = ~clk;

  digit_argmax dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_digit  (out_digit),
    .out_score  (out_score),
    .out_err    (out_err),
    .out_margin (out_margin)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input int gap_max);
    for (int i = 0; i < fr_len; i++) begin
      send_beat(fr[i], (i == fr_len - 1));
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(posedge clk);
      #1;
    end
  endtask

  task automatic check_fields(input string tag, input logic [3:0] d, input logic [7:0] s,
                              input logic e, input logic [7:0] m);
    chk({tag, ".valid"},  32'(out_valid),  32'd1);
    chk({tag, ".digit"},  32'(out_digit),  32'(d));
    chk({tag, ".score"},  32'(out_score),  32'(s));
    chk({tag, ".err"},    32'(out_err),    32'(e));
    chk({tag, ".margin"}, 32'(out_margin), MEN ? 32'(m) : 32'd0);
  endtask

  task automatic get_result(input string tag, input logic [3:0] d, input logic [7:0] s,
                            input logic e, input logic [7:0] m, input int hold);
    int t = 0;
    while (!out_valid && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check_fields(tag, d, s, e, m);
    repeat (hold) @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic model(output logic [3:0] d, output logic [7:0] s, output logic e,
                       output logic [7:0] m);
    int n, bi, best, ru;
    n    = (fr_len < N) ? fr_len : N;
    best = int'(fr[0]);
    bi   = 0;
    for (int i = 1; i < n; i++) if (int'(fr[i]) > best) begin best = int'(fr[i]); bi = i; end
    ru = 0;
    for (int i = 0; i < n; i++) if (i != bi && int'(fr[i]) > ru) ru = int'(fr[i]);
    d = 4'(bi);
    s = 8'(best);
    e = (fr_len != N);
    m = 8'(best - ru);
  endtask

  initial begin
    logic [3:0] md;
    logic [7:0] ms, mm;
    logic       me;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst.in_ready",  32'(in_ready),   32'd1);
    chk("rst.out_valid", 32'(out_valid),  32'd0);
    chk("rst.digit",     32'(out_digit),  32'd0);
    chk("rst.score",     32'(out_score),  32'd0);
    chk("rst.err",       32'(out_err),    32'd0);
    chk("rst.margin",    32'(out_margin), 32'd0);

    // Ascending 10..100: digit 9, score 100, margin 10.
    fr_len = 10;
    for (int i = 0; i < 10; i++) fr[i] = 8'(10 * (i + 1));
    send_frame(0);
    get_result("asc", 4'd9, 8'd100, 1'b0, 8'd10, 0);

    // Tie at classes 3 and 7: lower index wins, margin 0.
    for (int i = 0; i < 10; i++) fr[i] = 8'd5;
    fr[3] = 8'd200; fr[7] = 8'd200;
    send_frame(1);
    get_result("tie", 4'd3, 8'd200, 1'b0, 8'd0, 2);

    // Short frame of 8 beats: 150 at class 2, others 10*i -> runner-up 70.
    fr_len = 8;
    for (int i = 0; i < 8; i++) fr[i] = 8'(10 * i);
    fr[2] = 8'd150;
    send_frame(0);
    get_result("short", 4'd2, 8'd150, 1'b1, 8'd80, 0);

    // Long frame of 12 beats: trailing 255s must not count.
    fr_len = 12;
    for (int i = 0; i < 10; i++) fr[i] = 8'd50;
    fr[4] = 8'd90; fr[10] = 8'd255; fr[11] = 8'd255;
    send_frame(0);
    get_result("long", 4'd4, 8'd90, 1'b1, 8'd40, 0);

    // Single-beat frame.
    fr_len = 1; fr[0] = 8'd77;
    send_frame(0);
    get_result("single", 4'd0, 8'd77, 1'b1, 8'd77, 0);

    // Consumer stall: descending 100..10 with upstream pushing for 20 cycles.
    fr_len = 10;
    for (int i = 0; i < 10; i++) fr[i] = 8'(100 - 10 * i);
    send_frame(0);
    check_fields("stall0", 4'd0, 8'd100, 1'b0, 8'd10);
    in_valid = 1'b1; in_data = 8'hEE;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk("stall.in_ready", 32'(in_ready),  32'd0);
      chk("stall.valid",    32'(out_valid), 32'd1);
      chk("stall.score",    32'(out_score), 32'd100);
      chk("stall.digit",    32'(out_digit), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release.in_ready", 32'(in_ready),  32'd1);
    chk("release.valid",    32'(out_valid), 32'd0);
    in_valid = 1'b0;
    fr[0] = 8'd3; fr[1] = 8'd1; fr[2] = 8'd4; fr[3] = 8'd1; fr[4] = 8'd5;
    fr[5] = 8'd9; fr[6] = 8'd2; fr[7] = 8'd6; fr[8] = 8'd5; fr[9] = 8'd3;
    send_frame(0);
    get_result("after_stall", 4'd5, 8'd9, 1'b0, 8'd3, 0);

    // Asynchronous reset after beat 5 of a frame of 250s.
    for (int i = 0; i < 5; i++) send_beat(8'd250, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst.valid",  32'(out_valid),  32'd0);
    chk("arst.digit",  32'(out_digit),  32'd0);
    chk("arst.score",  32'(out_score),  32'd0);
    chk("arst.err",    32'(out_err),    32'd0);
    chk("arst.margin", 32'(out_margin), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) fr[i] = 8'(i + 7);
    send_frame(0);
    get_result("post_rst", 4'd9, 8'd16, 1'b0, 8'd1, 0);

    // Random frames with valid gaps and consumer delay against the model.
    for (int f = 0; f < 1000; f++) begin
      fr_len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 12)) : 10;
      for (int i = 0; i < fr_len; i++)
        fr[i] = 8'($urandom_range(0, (f % 2 == 0) ? 255 : 7));
      model(md, ms, me, mm);
      send_frame(2);
      get_result($sformatf("rand%0d", f), md, ms, me, mm, int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
